// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller: FSM states, report word
// indices and status-word bit positions.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StReport,
        StDone
    } state_e;

    localparam int unsigned RPT_W    = 32;
    localparam int unsigned RPT_CYC  = 0;
    localparam int unsigned RPT_INS  = 1;
    localparam int unsigned RPT_STAT = 2;

    localparam int unsigned STAT_HALT = 0;
    localparam int unsigned STAT_TMO  = 1;

endpackage

// File: rtl/sat_accum.sv
// Width-parameterised accumulator with clear, enable and zero-extended addend;
// optionally saturates at all-ones instead of wrapping.
module sat_accum #(
    parameter int unsigned W        = 8,
    parameter int unsigned ADD_W    = 3,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [ADD_W-1:0] addend_i,
    output logic [W-1:0]     value_o
);

    logic [W-1:0] value_q, value_d;
    logic [W:0]   sum;

    // Carry into bit W flags overflow; needs W >= ADD_W so one add overflows at most once.
    assign sum = {1'b0, value_q} + (W+1)'(addend_i);

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (en_i) begin
            if (SATURATE && sum[W]) begin
                value_d = '1;
            end else begin
                value_d = sum[W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/run_ctrl.sv
// Program-run sequencer: gates the core, counts cycles and retired instructions,
// drains late writebacks after halt and streams a 3-word result record.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned CYC_W        = 23,
    parameter int unsigned INS_W        = 32,
    parameter int unsigned MAX_CYCLES   = 100000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             isHalt,
    input  logic [2:0]       W_v,
    output logic             run,
    output logic [CYC_W-1:0] cycle,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [RPT_W-1:0] rpt_data,
    output logic             rpt_last,
    output logic             done,
    output logic             timeout
);

    localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e           state_q;
    logic [DRN_W-1:0] drain_q;
    logic [1:0]       idx_q;
    logic             run_q, valid_q, last_q, done_q, tmo_q, halted_q;

    logic             cnt_clr, cyc_en, ins_en, wd_hit;
    logic [CYC_W-1:0] cyc_val;
    logic [INS_W-1:0] ins_val;
    logic [RPT_W-1:0] stat_word;

    assign cnt_clr = start && (state_q == StIdle || state_q == StDone);
    assign cyc_en  = (state_q == StRun);
    assign ins_en  = (state_q == StRun) || (state_q == StDrain);
    assign wd_hit  = (cyc_val + CYC_W'(1)) == CYC_W'(MAX_CYCLES);

    sat_accum #(
        .W        (CYC_W),
        .ADD_W    (3),
        .SATURATE (1'b0)
    ) u_cyc_cnt (
        .clk_i    (clk),
        .reset_i  (reset),
        .clr_i    (cnt_clr),
        .en_i     (cyc_en),
        .addend_i (3'd1),
        .value_o  (cyc_val)
    );

    sat_accum #(
        .W        (INS_W),
        .ADD_W    (3),
        .SATURATE (1'b1)
    ) u_ins_cnt (
        .clk_i    (clk),
        .reset_i  (reset),
        .clr_i    (cnt_clr),
        .en_i     (ins_en),
        .addend_i (W_v),
        .value_o  (ins_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            drain_q  <= '0;
            idx_q    <= '0;
            run_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q  <= StRun;
                        run_q    <= 1'b1;
                        done_q   <= 1'b0;
                        tmo_q    <= 1'b0;
                        halted_q <= 1'b0;
                    end
                end
                StRun: begin
                    // Halt takes priority over a watchdog hit on the same cycle.
                    if (isHalt) begin
                        state_q  <= StDrain;
                        run_q    <= 1'b0;
                        halted_q <= 1'b1;
                        drain_q  <= '0;
                    end else if (wd_hit) begin
                        state_q <= StReport;
                        run_q   <= 1'b0;
                        tmo_q   <= 1'b1;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        last_q  <= 1'b0;
                    end
                end
                StDrain: begin
                    if (drain_q == DRN_W'(DRAIN_CYCLES - 1)) begin
                        state_q <= StReport;
                        valid_q <= 1'b1;
                        idx_q   <= '0;
                        last_q  <= 1'b0;
                    end else begin
                        drain_q <= drain_q + DRN_W'(1);
                    end
                end
                StReport: begin
                    if (rpt_ready) begin
                        if (idx_q == 2'(RPT_STAT)) begin
                            state_q <= StDone;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + 2'd1;
                            last_q <= (idx_q == 2'(RPT_INS));
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stat_word            = '0;
        stat_word[STAT_HALT] = halted_q;
        stat_word[STAT_TMO]  = tmo_q;
    end

    // Counters are frozen in REPORT, so the word mux is stable while stalled.
    always_comb begin
        rpt_data = '0;
        if (valid_q) begin
            case (idx_q)
                2'(RPT_CYC): rpt_data = RPT_W'(cyc_val);
                2'(RPT_INS): rpt_data = RPT_W'(ins_val);
                default:     rpt_data = stat_word;
            endcase
        end
    end

    assign run       = run_q;
    assign cycle     = cyc_val;
    assign rpt_valid = valid_q;
    assign rpt_last  = last_q;
    assign done      = done_q;
    assign timeout   = tmo_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: two instances (32-bit and 4-bit instruction
// counters) driven in lock-step and checked against an arithmetic run model.
module tb_run_ctrl;

    localparam int unsigned MAXC = 300;
    localparam int unsigned DRN  = 4;

    logic        clk = 1'b0;
    logic        reset, start, is_halt, rpt_ready;
    logic [2:0]  w_v;

    logic        run_a, valid_a, last_a, done_a, tmo_a;
    logic [22:0] cycle_a;
    logic [31:0] data_a;
    logic        run_b, valid_b, last_b, done_b, tmo_b;
    logic [22:0] cycle_b;
    logic [31:0] data_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .CYC_W(23), .INS_W(32), .MAX_CYCLES(MAXC), .DRAIN_CYCLES(DRN)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .isHalt(is_halt), .W_v(w_v),
        .run(run_a), .cycle(cycle_a), .rpt_valid(valid_a), .rpt_ready(rpt_ready),
        .rpt_data(data_a), .rpt_last(last_a), .done(done_a), .timeout(tmo_a)
    );

    run_ctrl #(
        .CYC_W(23), .INS_W(4), .MAX_CYCLES(MAXC), .DRAIN_CYCLES(DRN)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start), .isHalt(is_halt), .W_v(w_v),
        .run(run_b), .cycle(cycle_b), .rpt_valid(valid_b), .rpt_ready(rpt_ready),
        .rpt_data(data_b), .rpt_last(last_b), .done(done_b), .timeout(tmo_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] pick_wv(input int sel);
        return (sel < 8) ? 3'(sel) : 3'($urandom_range(7, 0));
    endfunction

    // halt_at: RUN cycle (1-based) carrying isHalt; beyond MAXC means watchdog.
    // ready_mode: 0 always ready, 1 pattern 0,0,1,0,1,1, 2 random.
    task automatic do_run(input string name, input int halt_at, input int wv_sel,
                          input int drain_sel, input int ready_mode);
        longint      sum;
        int          k, ncyc, got;
        bit          halted, prev_stall;
        bit          pat [6];
        logic [31:0] prev_data;
        logic [63:0] exp_a [3];
        logic [63:0] exp_b [3];
        sum = 0; halted = 0; got = 0; prev_stall = 0; prev_data = '0;
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, ".run_on"},  64'(run_a),   64'(1));
        check({name, ".cyc_clr"}, 64'(cycle_a), 64'(0));
        check({name, ".done_clr"}, 64'({done_a, done_b}), 64'(0));
        check({name, ".tmo_clr"},  64'({tmo_a, tmo_b}),   64'(0));

        for (k = 1; k <= int'(MAXC); k++) begin
            w_v     = pick_wv(wv_sel);
            is_halt = (k == halt_at);
            sum    += 64'(w_v);
            tick();
            if (is_halt) begin
                halted = 1'b1;
                break;
            end
        end
        is_halt = 1'b0;
        ncyc    = halted ? k : int'(MAXC);
        check({name, ".run_off"}, 64'(run_a), 64'(0));

        if (halted) begin
            for (int d = 0; d < int'(DRN); d++) begin
                check({name, ".drain_novalid"}, 64'(valid_a), 64'(0));
                check({name, ".drain_cyc"},     64'(cycle_a), 64'(ncyc));
                w_v  = pick_wv(drain_sel);
                sum += 64'(w_v);
                tick();
            end
        end
        check({name, ".valid_on"}, 64'({valid_a, valid_b}), 64'(3));

        exp_a[0] = 64'(ncyc);
        exp_a[1] = (sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(sum);
        exp_a[2] = halted ? 64'(1) : 64'(2);
        exp_b[0] = exp_a[0];
        exp_b[1] = (sum > 15) ? 64'(15) : 64'(sum);
        exp_b[2] = exp_a[2];

        for (int c = 0; c < 40 && got < 3; c++) begin
            w_v       = 3'($urandom_range(7, 0));
            rpt_ready = (ready_mode == 0) ? 1'b1 :
                        (ready_mode == 1) ? pat[c % 6] : 1'($urandom_range(1, 0));
            check({name, ".rpt_valid"}, 64'(valid_a), 64'(1));
            check({name, ".rpt_last"},  64'({last_a, last_b}), (got == 2) ? 64'(3) : 64'(0));
            if (prev_stall) check({name, ".hold"}, 64'(data_a), 64'(prev_data));
            if (rpt_ready) begin
                check({name, ".word_a"}, 64'(data_a), exp_a[got]);
                check({name, ".word_b"}, 64'(data_b), exp_b[got]);
                got++;
            end
            prev_stall = !rpt_ready;
            prev_data  = data_a;
            tick();
        end
        rpt_ready = 1'b0;

        check({name, ".xfers"},    64'(got), 64'(3));
        check({name, ".done"},     64'({done_a, done_b}),   64'(3));
        check({name, ".valid_off"}, 64'({valid_a, valid_b}), 64'(0));
        check({name, ".timeout"},  64'(tmo_a),   halted ? 64'(0) : 64'(1));
        check({name, ".final_cyc"}, 64'(cycle_a), 64'(ncyc));
    endtask

    initial begin
        int seen_valid;
        reset = 1'b1; start = 1'b0; is_halt = 1'b0; w_v = '0; rpt_ready = 1'b0;
        repeat (3) tick();
        check("rst.run",   64'({run_a, run_b}),     64'(0));
        check("rst.cycle", 64'(cycle_a),            64'(0));
        check("rst.valid", 64'({valid_a, valid_b}), 64'(0));
        check("rst.last",  64'(last_a),             64'(0));
        check("rst.data",  64'(data_a),             64'(0));
        check("rst.done",  64'(done_a),             64'(0));
        check("rst.tmo",   64'(tmo_a),              64'(0));
        reset = 1'b0;
        tick();
        check("idle.hold", 64'(run_a), 64'(0));

        do_run("halt10", 10, 2, 1, 0);
        do_run("wdog",   int'(MAXC) + 1, 1, 1, 0);
        do_run("coinc",  int'(MAXC), 8, 8, 2);
        do_run("stall",  int'($urandom_range(40, 5)), 8, 8, 1);

        // Reset in the middle of a run.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            w_v = 3'($urandom_range(7, 0));
            tick();
        end
        check("mid.cyc50", 64'(cycle_a), 64'(50));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid.run",   64'(run_a),   64'(0));
        check("mid.cycle", 64'(cycle_a), 64'(0));
        check("mid.done",  64'(done_a),  64'(0));
        seen_valid = 0;
        for (int k = 0; k < 12; k++) begin
            rpt_ready = 1'b1;
            if (valid_a || valid_b) seen_valid++;
            tick();
        end
        rpt_ready = 1'b0;
        check("mid.novalid", 64'(seen_valid), 64'(0));

        do_run("sat", 5, 7, 7, 0);
        for (int i = 0; i < 4; i++) begin
            do_run("rand", int'($urandom_range(MAXC + 40, 1)), 8, 8, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
